// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS-subset datapath.
// Walks each instruction through IF/ID/EX/MEM/WB style states, stalls on
// mem_ready in the memory states and traps on unsupported encodings.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemR,
  output logic       MemW,
  output logic       Mem2R,
  output logic       RegDst,
  output logic       RegW,
  output logic       ALUSrcA,
  output logic [1:0] Alusrc,
  output logic [1:0] ExtOp,
  output logic [4:0] Aluctrl,
  output logic       InsRet,
  output logic       Illegal,
  output logic [3:0] State
);

  // Opcodes (standard MIPS encodings)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;

  // ALU operation codes
  localparam logic [4:0] ALUOP_NOP  = 5'd0;
  localparam logic [4:0] ALUOP_ADDU = 5'd1;
  localparam logic [4:0] ALUOP_ADD  = 5'd2;
  localparam logic [4:0] ALUOP_SUBU = 5'd3;
  localparam logic [4:0] ALUOP_SUB  = 5'd4;
  localparam logic [4:0] ALUOP_AND  = 5'd5;
  localparam logic [4:0] ALUOP_OR   = 5'd6;
  localparam logic [4:0] ALUOP_SLL  = 5'd7;
  localparam logic [4:0] ALUOP_SRL  = 5'd8;
  localparam logic [4:0] ALUOP_SLT  = 5'd9;
  localparam logic [4:0] ALUOP_EQL  = 5'd10;
  localparam logic [4:0] ALUOP_BNE  = 5'd11;

  // Immediate extension codes
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_EX   = 4'd3,
    S_WB   = 4'd4,
    S_MA   = 4'd5,
    S_MR   = 4'd6,
    S_LWB  = 4'd7,
    S_MW   = 4'd8,
    S_BR   = 4'd9,
    S_J    = 4'd10,
    S_TRAP = 4'd11
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   illegal_r;

  // Legal R-type function codes; anything else traps.
  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
      FN_OR, FN_SLT, FN_SLL, FN_SRL: funct_legal = 1'b1;
      default:                       funct_legal = 1'b0;
    endcase
  endfunction

  // funct -> ALU operation, same mapping as the single-cycle decoder.
  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD:  funct_alu = ALUOP_ADD;
      FN_ADDU: funct_alu = ALUOP_ADDU;
      FN_SUB:  funct_alu = ALUOP_SUB;
      FN_SUBU: funct_alu = ALUOP_SUBU;
      FN_AND:  funct_alu = ALUOP_AND;
      FN_OR:   funct_alu = ALUOP_OR;
      FN_SLT:  funct_alu = ALUOP_SLT;
      FN_SLL:  funct_alu = ALUOP_SLL;
      FN_SRL:  funct_alu = ALUOP_SRL;
      default: funct_alu = ALUOP_ADDU;
    endcase
  endfunction

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky trap flag, set on the edge that enters TRAP, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == S_TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state and control decode from current state, opcode/funct and handshakes.
  always_comb begin
    next_state_s = S_INIT;
    PCWr     = 1'b0;
    PCSource = 2'b00;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemR     = 1'b0;
    MemW     = 1'b0;
    Mem2R    = 1'b0;
    RegDst   = 1'b0;
    RegW     = 1'b0;
    ALUSrcA  = 1'b0;
    Alusrc   = 2'b00;
    ExtOp    = EXT_ZERO;
    Aluctrl  = ALUOP_ADDU;
    InsRet   = 1'b0;

    case (state_r)
      S_INIT: begin
        Aluctrl      = ALUOP_NOP;
        next_state_s = S_IF;
      end
      S_IF: begin
        MemR = 1'b1;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWr         = 1'b1;
          Alusrc       = 2'b01;
          next_state_s = S_ID;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_ID: begin
        // Branch target (PC+4 + imm<<2) is computed here into ALUOut.
        Alusrc  = 2'b11;
        ExtOp   = EXT_SIGNED;
        Aluctrl = ALUOP_ADD;
        case (OpCode)
          OP_RTYPE: next_state_s = funct_legal(funct) ? S_EX : S_TRAP;
          OP_ORI, OP_SLTI, OP_LUI: next_state_s = S_EX;
          OP_LW, OP_SW:            next_state_s = S_MA;
          OP_BEQ, OP_BNE:          next_state_s = S_BR;
          OP_J:                    next_state_s = S_J;
          default:                 next_state_s = S_TRAP;
        endcase
      end
      S_EX: begin
        ALUSrcA = 1'b1;
        case (OpCode)
          OP_RTYPE: begin
            Alusrc  = 2'b00;
            Aluctrl = funct_alu(funct);
          end
          OP_ORI: begin
            Alusrc  = 2'b10;
            ExtOp   = EXT_ZERO;
            Aluctrl = ALUOP_OR;
          end
          OP_SLTI: begin
            Alusrc  = 2'b10;
            ExtOp   = EXT_SIGNED;
            Aluctrl = ALUOP_SLT;
          end
          OP_LUI: begin
            Alusrc  = 2'b10;
            ExtOp   = EXT_HIGHPOS;
            Aluctrl = ALUOP_ADDU;
          end
          default: begin
            Alusrc  = 2'b00;
            Aluctrl = ALUOP_ADDU;
          end
        endcase
        next_state_s = S_WB;
      end
      S_WB: begin
        RegW         = 1'b1;
        RegDst       = (OpCode == OP_RTYPE);
        InsRet       = 1'b1;
        next_state_s = S_IF;
      end
      S_MA: begin
        ALUSrcA      = 1'b1;
        Alusrc       = 2'b10;
        ExtOp        = EXT_SIGNED;
        Aluctrl      = ALUOP_ADD;
        next_state_s = (OpCode == OP_SW) ? S_MW : S_MR;
      end
      S_MR: begin
        MemR         = 1'b1;
        IorD         = 1'b1;
        next_state_s = mem_ready ? S_LWB : S_MR;
      end
      S_LWB: begin
        RegW         = 1'b1;
        Mem2R        = 1'b1;
        InsRet       = 1'b1;
        next_state_s = S_IF;
      end
      S_MW: begin
        MemW = 1'b1;
        IorD = 1'b1;
        if (mem_ready) begin
          InsRet       = 1'b1;
          next_state_s = S_IF;
        end else begin
          next_state_s = S_MW;
        end
      end
      S_BR: begin
        ALUSrcA      = 1'b1;
        Alusrc       = 2'b00;
        Aluctrl      = (OpCode == OP_BNE) ? ALUOP_BNE : ALUOP_EQL;
        PCSource     = 2'b01;
        PCWr         = Zero;
        InsRet       = 1'b1;
        next_state_s = S_IF;
      end
      S_J: begin
        PCWr         = 1'b1;
        PCSource     = 2'b10;
        InsRet       = 1'b1;
        next_state_s = S_IF;
      end
      S_TRAP: begin
        Aluctrl      = ALUOP_NOP;
        next_state_s = S_TRAP;
      end
      default: begin
        Aluctrl      = ALUOP_NOP;
        next_state_s = S_INIT;
      end
    endcase
  end

  assign Illegal = illegal_r;
  assign State   = state_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Each cycle the stimulus pushes
// the expected state and control vector; a negedge monitor pops and compares.
module tb_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] OpCode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWr;
  logic [1:0] PCSource;
  logic       IorD;
  logic       IRWrite;
  logic       MemR;
  logic       MemW;
  logic       Mem2R;
  logic       RegDst;
  logic       RegW;
  logic       ALUSrcA;
  logic [1:0] Alusrc;
  logic [1:0] ExtOp;
  logic [4:0] Aluctrl;
  logic       InsRet;
  logic       Illegal;
  logic [3:0] State;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .PCSource(PCSource), .IorD(IorD),
    .IRWrite(IRWrite), .MemR(MemR), .MemW(MemW), .Mem2R(Mem2R),
    .RegDst(RegDst), .RegW(RegW), .ALUSrcA(ALUSrcA), .Alusrc(Alusrc),
    .ExtOp(ExtOp), .Aluctrl(Aluctrl), .InsRet(InsRet), .Illegal(Illegal),
    .State(State)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [21:0] o;
  } exp_t;

  exp_t sb_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  // ALU / extension codes the controller is expected to drive
  localparam logic [4:0] A_NOP = 5'd0, A_ADDU = 5'd1, A_ADD = 5'd2, A_SUB = 5'd4,
                         A_OR = 5'd6, A_EQL = 5'd10, A_BNE = 5'd11;
  localparam logic [1:0] X_Z = 2'd0, X_S = 2'd1;
  localparam logic [3:0] ST_INIT = 4'd0, ST_IF = 4'd1, ST_ID = 4'd2, ST_EX = 4'd3,
                         ST_WB = 4'd4, ST_MA = 4'd5, ST_MR = 4'd6, ST_LWB = 4'd7,
                         ST_MW = 4'd8, ST_BR = 4'd9, ST_J = 4'd10, ST_TRAP = 4'd11;

  logic [21:0] e_init, e_ifw, e_ifr, e_id, e_ex_addu, e_ex_sub, e_ex_ori, e_wb_r,
               e_wb_i, e_ma, e_mr, e_lwb, e_mww, e_mwr, e_beq1, e_beq0, e_bne1,
               e_j, e_trap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] ov(
    input logic pcwr, input logic [1:0] pcsrc, input logic iord, input logic irw,
    input logic memr, input logic memw, input logic m2r, input logic rdst,
    input logic regw, input logic srca, input logic [1:0] srcb,
    input logic [1:0] ext, input logic [4:0] aluc, input logic insret,
    input logic ill);
    ov = {pcwr, pcsrc, iord, irw, memr, memw, m2r, rdst, regw, srca, srcb, ext,
          aluc, insret, ill};
  endfunction

  // Scoreboard monitor: compare one expectation per cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("state", {28'd0, State}, {28'd0, e.st});
      chk("ctrl", {10'd0, PCWr, PCSource, IorD, IRWrite, MemR, MemW, Mem2R, RegDst,
                   RegW, ALUSrcA, Alusrc, ExtOp, Aluctrl, InsRet, Illegal},
          {10'd0, e.o});
    end
  end

  // Drive one cycle of inputs and queue the expectation for that cycle.
  task automatic cyc(input logic [3:0] st, input logic [21:0] o, input logic rdy,
                     input logic z, input logic rst);
    exp_t e;
    mem_ready = rdy;
    Zero      = z;
    rst_n     = rst;
    e.st      = st;
    e.o       = o;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          pcwr  pcs    iord  irw   memr  memw  m2r   rdst  regw  srca  srcb   ext  aluc    ret   ill
    e_init    = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_NOP, 1'b0,1'b0);
    e_ifw     = ov(1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_ADDU,1'b0,1'b0);
    e_ifr     = ov(1'b1,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,X_Z,A_ADDU,1'b0,1'b0);
    e_id      = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,X_S,A_ADD, 1'b0,1'b0);
    e_ex_addu = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,X_Z,A_ADDU,1'b0,1'b0);
    e_ex_sub  = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,X_Z,A_SUB, 1'b0,1'b0);
    e_ex_ori  = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,X_Z,A_OR,  1'b0,1'b0);
    e_wb_r    = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,X_Z,A_ADDU,1'b1,1'b0);
    e_wb_i    = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,X_Z,A_ADDU,1'b1,1'b0);
    e_ma      = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,X_S,A_ADD, 1'b0,1'b0);
    e_mr      = ov(1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_ADDU,1'b0,1'b0);
    e_lwb     = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,X_Z,A_ADDU,1'b1,1'b0);
    e_mww     = ov(1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_ADDU,1'b0,1'b0);
    e_mwr     = ov(1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_ADDU,1'b1,1'b0);
    e_beq1    = ov(1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,X_Z,A_EQL, 1'b1,1'b0);
    e_beq0    = ov(1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,X_Z,A_EQL, 1'b1,1'b0);
    e_bne1    = ov(1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,X_Z,A_BNE, 1'b1,1'b0);
    e_j       = ov(1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_ADDU,1'b1,1'b0);
    e_trap    = ov(1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,X_Z,A_NOP, 1'b0,1'b1);

    rst_n = 1'b0; OpCode = 6'b000000; funct = 6'b100001; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state then addu: 0,1,2,3,4,1
    cyc(ST_INIT, e_init,    1'b1, 1'b0, 1'b1);
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_EX,   e_ex_addu, 1'b1, 1'b0, 1'b1);
    cyc(ST_WB,   e_wb_r,    1'b1, 1'b0, 1'b1);

    // sub
    funct = 6'b100010;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_EX,   e_ex_sub,  1'b1, 1'b0, 1'b1);
    cyc(ST_WB,   e_wb_r,    1'b1, 1'b0, 1'b1);

    // lw with two wait cycles in MR: 7 cycles total
    OpCode = 6'b100011;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b0, 1'b0, 1'b1);
    cyc(ST_MA,   e_ma,      1'b0, 1'b0, 1'b1);
    cyc(ST_MR,   e_mr,      1'b0, 1'b0, 1'b1);
    cyc(ST_MR,   e_mr,      1'b0, 1'b0, 1'b1);
    cyc(ST_MR,   e_mr,      1'b1, 1'b0, 1'b1);
    cyc(ST_LWB,  e_lwb,     1'b0, 1'b0, 1'b1);

    // ori with one fetch wait cycle
    OpCode = 6'b001101;
    cyc(ST_IF,   e_ifw,     1'b0, 1'b0, 1'b1);
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_EX,   e_ex_ori,  1'b1, 1'b0, 1'b1);
    cyc(ST_WB,   e_wb_i,    1'b1, 1'b0, 1'b1);

    // beq taken, beq not taken, bne taken
    OpCode = 6'b000100;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_BR,   e_beq1,    1'b1, 1'b1, 1'b1);
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_BR,   e_beq0,    1'b1, 1'b0, 1'b1);
    OpCode = 6'b000101;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_BR,   e_bne1,    1'b1, 1'b1, 1'b1);

    // j
    OpCode = 6'b000010;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_J,    e_j,       1'b1, 1'b0, 1'b1);

    // sw with one write wait cycle
    OpCode = 6'b101011;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_MA,   e_ma,      1'b1, 1'b0, 1'b1);
    cyc(ST_MW,   e_mww,     1'b0, 1'b0, 1'b1);
    cyc(ST_MW,   e_mwr,     1'b1, 1'b0, 1'b1);

    // sw reset during an MW wait: abandoned, no InsRet, back to INIT
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_MA,   e_ma,      1'b0, 1'b0, 1'b1);
    cyc(ST_MW,   e_mww,     1'b0, 1'b0, 1'b0);
    cyc(ST_INIT, e_init,    1'b1, 1'b0, 1'b1);

    // Illegal opcode: TRAP held 20 cycles, then reset clears Illegal
    OpCode = 6'b111111;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(ST_TRAP, e_trap, 1'b1, 1'b1, (i == 19) ? 1'b0 : 1'b1);
    end
    cyc(ST_INIT, e_init,    1'b1, 1'b0, 1'b1);

    // R-type with an unsupported funct also traps
    OpCode = 6'b000000; funct = 6'b111111;
    cyc(ST_IF,   e_ifr,     1'b1, 1'b0, 1'b1);
    cyc(ST_ID,   e_id,      1'b1, 1'b0, 1'b1);
    cyc(ST_TRAP, e_trap,    1'b1, 1'b0, 1'b0);
    cyc(ST_INIT, e_init,    1'b1, 1'b0, 1'b1);
    cyc(ST_IF,   e_ifw,     1'b0, 1'b0, 1'b1);

    #6;
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
